// File: rtl/lcd_timing_gen_if.sv
// Frame-buffer read side of the LCD timing generator:
// pixel request, coordinates, panel geometry and the returned pixel.
interface lcd_timing_gen_if;
    logic        data_req;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic [10:0] h_disp;
    logic [10:0] v_disp;
    logic        frame_start;
    logic [23:0] pixel_data;

    modport master (
        output data_req, pixel_xpos, pixel_ypos,
        output h_disp, v_disp, frame_start,
        input  pixel_data
    );

    modport slave (
        input  data_req, pixel_xpos, pixel_ypos,
        input  h_disp, v_disp, frame_start,
        output pixel_data
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// RGB panel timing generator: picks timing from the panel ID,
// drives HS/VS/DE, requests pixels one cycle early and gates RGB out.
module lcd_timing_gen #(
    parameter logic SYNC_ACT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      lcd_id,
    lcd_timing_gen_if.master fb,
    output logic             lcd_hs,
    output logic             lcd_vs,
    output logic             lcd_de,
    output logic             lcd_bl,
    output logic             lcd_rst,
    output logic [23:0]      lcd_rgb
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]  r_state;
    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;

    logic [10:0] r_h_sync;
    logic [10:0] r_h_beg;
    logic [10:0] r_h_end;
    logic [10:0] r_h_total;
    logic [10:0] r_h_disp;
    logic [10:0] r_v_sync;
    logic [10:0] r_v_beg;
    logic [10:0] r_v_end;
    logic [10:0] r_v_total;
    logic [10:0] r_v_disp;

    logic        r_hs;
    logic        r_vs;
    logic        r_de;
    logic        r_req;
    logic [10:0] r_xpos;
    logic [10:0] r_ypos;
    logic        r_fs;
    logic        r_bl;
    logic        r_rst;
    logic [23:0] r_rgb;

    logic [10:0] w_hs;
    logic [10:0] w_hb;
    logic [10:0] w_hd;
    logic [10:0] w_ht;
    logic [10:0] w_vs;
    logic [10:0] w_vb;
    logic [10:0] w_vd;
    logic [10:0] w_vt;

    // Unknown non-zero IDs fall back to the 7084 timing.
    always_comb begin
        w_hs = 11'd128; w_hb = 11'd88; w_hd = 11'd800;  w_ht = 11'd1056;
        w_vs = 11'd2;   w_vb = 11'd33; w_vd = 11'd480;  w_vt = 11'd525;
        unique case (1'b1)
            (lcd_id == 16'h4342): begin
                w_hs = 11'd41;  w_hb = 11'd2;   w_hd = 11'd480;  w_ht = 11'd525;
                w_vs = 11'd10;  w_vb = 11'd2;   w_vd = 11'd272;  w_vt = 11'd286;
            end
            (lcd_id == 16'h7016): begin
                w_hs = 11'd20;  w_hb = 11'd140; w_hd = 11'd1024; w_ht = 11'd1344;
                w_vs = 11'd3;   w_vb = 11'd20;  w_vd = 11'd600;  w_vt = 11'd635;
            end
            (lcd_id == 16'h4384): begin
                w_hs = 11'd48;  w_hb = 11'd88;  w_hd = 11'd800;  w_ht = 11'd976;
                w_vs = 11'd3;   w_vb = 11'd32;  w_vd = 11'd480;  w_vt = 11'd528;
            end
            (lcd_id == 16'h1018): begin
                w_hs = 11'd10;  w_hb = 11'd80;  w_hd = 11'd1280; w_ht = 11'd1440;
                w_vs = 11'd3;   w_vb = 11'd10;  w_vd = 11'd800;  w_vt = 11'd823;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_h_cnt <= 11'd0;
            r_v_cnt <= 11'd0;
        end else begin
            unique case (r_state)
                S_IDLE: if (lcd_id != 16'd0) r_state <= S_LOAD;
                S_LOAD: r_state <= S_RUN;
                S_RUN: begin
                    if (r_h_cnt == r_h_total - 11'd1) begin
                        r_h_cnt <= 11'd0;
                        if (r_v_cnt == r_v_total - 11'd1)
                            r_v_cnt <= 11'd0;
                        else
                            r_v_cnt <= r_v_cnt + 11'd1;
                    end else begin
                        r_h_cnt <= r_h_cnt + 11'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_sync  <= 11'd0;
            r_h_beg   <= 11'd0;
            r_h_end   <= 11'd0;
            r_h_total <= 11'd0;
            r_h_disp  <= 11'd0;
            r_v_sync  <= 11'd0;
            r_v_beg   <= 11'd0;
            r_v_end   <= 11'd0;
            r_v_total <= 11'd0;
            r_v_disp  <= 11'd0;
        end else if (r_state == S_LOAD) begin
            r_h_sync  <= w_hs;
            r_h_beg   <= w_hs + w_hb;
            r_h_end   <= w_hs + w_hb + w_hd;
            r_h_total <= w_ht;
            r_h_disp  <= w_hd;
            r_v_sync  <= w_vs;
            r_v_beg   <= w_vs + w_vb;
            r_v_end   <= w_vs + w_vb + w_vd;
            r_v_total <= w_vt;
            r_v_disp  <= w_vd;
        end
    end

    logic        w_run;
    logic [10:0] w_h_nx;
    logic        w_h_de;
    logic        w_h_rq;
    logic        w_v_de;
    logic        w_de;
    logic        w_rq;

    // Request window is the DE window seen from the next h_cnt.
    assign w_run  = (r_state == S_RUN);
    assign w_h_nx = r_h_cnt + 11'd1;
    assign w_h_de = (r_h_cnt >= r_h_beg) && (r_h_cnt < r_h_end);
    assign w_h_rq = (w_h_nx >= r_h_beg) && (w_h_nx < r_h_end);
    assign w_v_de = (r_v_cnt >= r_v_beg) && (r_v_cnt < r_v_end);
    assign w_de   = w_run && w_h_de && w_v_de;
    assign w_rq   = w_run && w_h_rq && w_v_de;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs   <= ~SYNC_ACT;
            r_vs   <= ~SYNC_ACT;
            r_de   <= 1'b0;
            r_req  <= 1'b0;
            r_xpos <= 11'd0;
            r_ypos <= 11'd0;
            r_fs   <= 1'b0;
            r_bl   <= 1'b0;
            r_rst  <= 1'b0;
            r_rgb  <= 24'd0;
        end else begin
            r_hs   <= (w_run && r_h_cnt < r_h_sync) ? SYNC_ACT : ~SYNC_ACT;
            r_vs   <= (w_run && r_v_cnt < r_v_sync) ? SYNC_ACT : ~SYNC_ACT;
            r_de   <= w_de;
            r_req  <= w_rq;
            r_xpos <= w_rq ? w_h_nx - r_h_beg : 11'd0;
            r_ypos <= w_rq ? r_v_cnt - r_v_beg : 11'd0;
            r_fs   <= w_run && (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);
            r_bl   <= r_bl | (r_state == S_LOAD);
            r_rst  <= r_rst | (r_state == S_LOAD);
            r_rgb  <= w_de ? fb.pixel_data : 24'd0;
        end
    end

    assign fb.data_req    = r_req;
    assign fb.pixel_xpos  = r_xpos;
    assign fb.pixel_ypos  = r_ypos;
    assign fb.h_disp      = r_h_disp;
    assign fb.v_disp      = r_v_disp;
    assign fb.frame_start = r_fs;

    assign lcd_hs  = r_hs;
    assign lcd_vs  = r_vs;
    assign lcd_de  = r_de;
    assign lcd_bl  = r_bl;
    assign lcd_rst = r_rst;
    assign lcd_rgb = r_rgb;

endmodule
